// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter controller for the single-cycle core. It owns the PC and
//   sequences fetch for up to three resident programs. A Start pulse launches
//   a program at its base address. A taken conditional branch loads the target
//   that the branch-target LUT returns. Stall, halt and PC overflow are handled
//   here.
//
//   Optional feature: define PC_SEQ_CYCLE_CNT_EN to add the CycleCnt and
//   TakenCnt saturating performance counters.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           asynchronous, active-high reset
//   start_i         launch request, honoured only in IDLE/HALT
//   prog_sel_i      program select at start (0..2 valid, 3 illegal)
//   stall_i         hold the PC this cycle
//   branch_en_i     current instruction is a conditional branch
//   branch_cond_i   branch condition flag from the ALU
//   branch_idx_i    LUT index field of the branch instruction
//   halt_i          current instruction is halt
//   lut_addr_o      index to the target LUT (combinational copy of branch_idx_i)
//   lut_target_i    target returned by the LUT in the same cycle
//   pc_o            registered program counter
//   busy_o          high while in RUN
//   done_o          high while in HALT
//   fault_o         sticky error flag (illegal select or PC overflow)
//   branch_taken_o  registered one-cycle pulse after a taken branch
//   cycle_cnt_o     (PC_SEQ_CYCLE_CNT_EN) number of RUN cycles, saturating
//   taken_cnt_o     (PC_SEQ_CYCLE_CNT_EN) number of taken branches, saturating
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PC_W    = 12,
    parameter int IDX_W   = 4,
    parameter int P0_BASE = 0,
    parameter int P1_BASE = 150,
    parameter int P2_BASE = 620
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       prog_sel_i,
    input  logic             stall_i,
    input  logic             branch_en_i,
    input  logic             branch_cond_i,
    input  logic [IDX_W-1:0] branch_idx_i,
    input  logic             halt_i,
    output logic [IDX_W-1:0] lut_addr_o,
    input  logic [PC_W-1:0]  lut_target_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fault_o,
`ifdef PC_SEQ_CYCLE_CNT_EN
    output logic [15:0]      cycle_cnt_o,
    output logic [15:0]      taken_cnt_o,
`endif
    output logic             branch_taken_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [PC_W-1:0] PC_MAX = '1;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic            taken_q, taken_d;

    // Decode events once so the optional counters share the FSM's view of them.
    logic valid_start;
    logic take_branch;

    assign lut_addr_o = branch_idx_i;

    // NOTE: every next-state signal gets a default at the top of the block, so
    // no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fault_d     = fault_q;
        taken_d     = 1'b0;
        valid_start = 1'b0;
        take_branch = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    if (prog_sel_i == 2'd3) begin
                        fault_d = 1'b1;
                    end else begin
                        valid_start = 1'b1;
                        fault_d     = 1'b0;
                        state_d     = ST_RUN;
                        case (prog_sel_i)
                            2'd0:    pc_d = PC_W'(P0_BASE);
                            2'd1:    pc_d = PC_W'(P1_BASE);
                            default: pc_d = PC_W'(P2_BASE);
                        endcase
                    end
                end
            end
            ST_RUN: begin
                // The rules are tested in priority order: stall, halt, taken
                // branch, then increment.
                if (stall_i) begin
                    pc_d = pc_q;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                end else if (branch_en_i && branch_cond_i) begin
                    take_branch = 1'b1;
                    pc_d        = lut_target_i;
                    taken_d     = 1'b1;
                end else if (pc_q == PC_MAX) begin
                    // Overflow does not wrap to 0. The PC parks at the top and
                    // the sequencer halts with a fault.
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            fault_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            taken_q <= taken_d;
        end
    end

    assign pc_o           = pc_q;
    assign busy_o         = (state_q == ST_RUN);
    assign done_o         = (state_q == ST_HALT);
    assign fault_o        = fault_q;
    assign branch_taken_o = taken_q;

`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (valid_start) begin
            cycle_cnt_d = '0;
            taken_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            // Stall cycles count as RUN cycles.
            if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
            if (take_branch && taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign taken_cnt_o = taken_cnt_q;
`else
    // Without the counters these decodes have no consumer.
    logic unused_events;
    assign unused_events = valid_start ^ take_branch;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed testbench for pc_sequencer. Inputs change 1 ns after each rising
//   edge. Outputs are sampled at that same point, where they have settled.
//   Every expected value below is computed by hand from the intended
//   sequencing behaviour.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  prog_sel;
    logic        stall;
    logic        branch_en;
    logic        branch_cond;
    logic [3:0]  branch_idx;
    logic        halt;
    logic [3:0]  lut_addr;
    logic [11:0] lut_target;
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic        fault;
    logic        branch_taken;
`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
    logic [15:0] taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .prog_sel_i     (prog_sel),
        .stall_i        (stall),
        .branch_en_i    (branch_en),
        .branch_cond_i  (branch_cond),
        .branch_idx_i   (branch_idx),
        .halt_i         (halt),
        .lut_addr_o     (lut_addr),
        .lut_target_i   (lut_target),
        .pc_o           (pc),
        .busy_o         (busy),
        .done_o         (done),
        .fault_o        (fault),
`ifdef PC_SEQ_CYCLE_CNT_EN
        .cycle_cnt_o    (cycle_cnt),
        .taken_cnt_o    (taken_cnt),
`endif
        .branch_taken_o (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start       = 1'b0;
        prog_sel    = 2'd0;
        stall       = 1'b0;
        branch_en   = 1'b0;
        branch_cond = 1'b0;
        branch_idx  = 4'd0;
        halt        = 1'b0;
        lut_target  = 12'd0;
    endtask

    task automatic do_branch(input logic [11:0] target);
        branch_en   = 1'b1;
        branch_cond = 1'b1;
        lut_target  = target;
        step();
        branch_en   = 1'b0;
        branch_cond = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #12;
        check("reset_pc",    pc, 0);
        check("reset_busy",  busy, 0);
        check("reset_done",  done, 0);
        check("reset_fault", fault, 0);
        check("reset_taken", branch_taken, 0);
        rst = 1'b0;
        step();

        // Launch program 1 and count up from its base.
        start = 1'b1; prog_sel = 2'd1;
        step();
        start = 1'b0;
        check("p1_base", pc, 150);
        check("p1_busy", busy, 1);
        check("p1_done", done, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("p1_incr", pc, 150 + i);
        end
        for (int i = 0; i < 5; i++) step();
        check("pc_160", pc, 160);

        // Taken branch: LUT index passes through combinationally.
        branch_en = 1'b1; branch_cond = 1'b1; branch_idx = 4'd1; lut_target = 12'd154;
        #1;
        check("lut_addr", lut_addr, 1);
        step();
        branch_en = 1'b0; branch_cond = 1'b0;
        check("br_pc",    pc, 154);
        check("br_taken", branch_taken, 1);
        step();
        check("br_after_pc",    pc, 155);
        check("br_taken_pulse", branch_taken, 0);

        // Back to 160, then a not-taken branch.
        do_branch(12'd160);
        check("br_back_160", pc, 160);
        branch_en = 1'b1; branch_cond = 1'b0; lut_target = 12'd5;
        step();
        branch_en = 1'b0;
        check("nt_pc",    pc, 161);
        check("nt_taken", branch_taken, 0);

        // Start is ignored in RUN.
        start = 1'b1; prog_sel = 2'd2;
        step();
        start = 1'b0;
        check("start_in_run_pc",    pc, 162);
        check("start_in_run_fault", fault, 0);

        // Stall dominates halt and a taken branch.
        do_branch(12'd700);
        check("pc_700", pc, 700);
        stall = 1'b1; halt = 1'b1; branch_en = 1'b1; branch_cond = 1'b1; lut_target = 12'd5;
        step();
        check("stall_pc",    pc, 700);
        check("stall_busy",  busy, 1);
        check("stall_taken", branch_taken, 0);
        stall = 1'b0;
        step();
        check("halt_pc",    pc, 700);
        check("halt_done",  done, 1);
        check("halt_busy",  busy, 0);
        check("halt_taken", branch_taken, 0);
        clear_inputs();
        step();
        check("halt_hold_pc", pc, 700);

        // Return to IDLE, then try an illegal program select.
        rst = 1'b1; #2; rst = 1'b0;
        start = 1'b1; prog_sel = 2'd3;
        step();
        start = 1'b0;
        check("illegal_fault", fault, 1);
        check("illegal_pc",    pc, 0);
        check("illegal_busy",  busy, 0);
        check("illegal_done",  done, 0);
        start = 1'b1; prog_sel = 2'd0;
        step();
        start = 1'b0;
        check("p0_fault", fault, 0);
        check("p0_pc",    pc, 0);
        check("p0_busy",  busy, 1);
        step();
        check("p0_incr", pc, 1);

        // Overflow: branch to the top, then attempt an increment.
        do_branch(12'd4095);
        check("top_pc",    pc, 4095);
        check("top_taken", branch_taken, 1);
        step();
        check("ovf_pc",    pc, 4095);
        check("ovf_fault", fault, 1);
        check("ovf_done",  done, 1);
        check("ovf_busy",  busy, 0);
        step();
        check("ovf_hold_pc", pc, 4095);
        check("ovf_sticky",  fault, 1);

        // Restart from HALT with program 2, then reset asynchronously mid-run.
        start = 1'b1; prog_sel = 2'd2;
        step();
        start = 1'b0;
        check("p2_pc",    pc, 620);
        check("p2_fault", fault, 0);
        check("p2_done",  done, 0);
`ifdef PC_SEQ_CYCLE_CNT_EN
        check("cnt_clear_cycle", cycle_cnt, 0);
        check("cnt_clear_taken", taken_cnt, 0);
`endif
        do_branch(12'd630);
        check("p2_br_630", pc, 630);
        check("p2_taken",  branch_taken, 1);
`ifdef PC_SEQ_CYCLE_CNT_EN
        check("cnt_cycle_1", cycle_cnt, 1);
        check("cnt_taken_1", taken_cnt, 1);
`endif
        #1;
        rst = 1'b1;
        #1;
        check("async_pc",    pc, 0);
        check("async_busy",  busy, 0);
        check("async_done",  done, 0);
        check("async_fault", fault, 0);
        check("async_taken", branch_taken, 0);
`ifdef PC_SEQ_CYCLE_CNT_EN
        check("async_cycle_cnt", cycle_cnt, 0);
        check("async_taken_cnt", taken_cnt, 0);
`endif
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
